// File: rtl/fifo_stream_fwft_pkg.sv
// Shared definitions for the streaming FWFT FIFO: width helpers and the
// prefetch-stage state encoding.
package fifo_stream_fwft_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_VALID = 2'd2
  } fwft_state_e;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so that 0..DEPTH is representable and full/empty pointers differ.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/block_ram_single_port.sv
// Single-clock RAM with one write port and one registered read port;
// an optional second output register adds one more cycle of read latency.
module block_ram_single_port #(
  parameter int    DATA_WIDTH      = 32,
  parameter int    ADDR_WIDTH      = 10,
  parameter string OUTPUT_REGISTER = "false"
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  if (OUTPUT_REGISTER == "true") begin : g_oreg
    logic [DATA_WIDTH-1:0] oreg_q;
    always_ff @(posedge clk_i) oreg_q <= rdata_q;
    assign rdata_o = oreg_q;
  end else begin : g_noreg
    assign rdata_o = rdata_q;
  end

endmodule

// File: rtl/fifo_counter.sv
// Wrapping pointer counter with increment enable and synchronous clear.
module fifo_counter #(
  parameter int WIDTH = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_fwft_stage.sv
// Prefetch stage: keeps the output register topped up from the RAM read
// register so that rd_data/rd_valid present the head word without a request.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// EMPTY    | output register holds nothing, no RAM read pending
// LOAD     | RAM read result waiting in the RAM read register, rd_valid=0
// VALID    | output register holds the head word, rd_valid=1
module fifo_fwft_stage
  import fifo_stream_fwft_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  ram_avail_i,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  ram_re_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  pop_o
);

  fwft_state_e           state_q, state_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  take;

  // pend_q marks an unconsumed word in the RAM read register; it is refilled
  // in the same cycle it is drained, which is what sustains 1 word/cycle.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    data_d   = data_q;
    ram_re_o = 1'b0;
    pop_o    = 1'b0;
    take     = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
      pend_d  = 1'b0;
      data_d  = '0;
    end else begin
      pop_o    = (state_q == ST_VALID) & rd_ready_i;
      take     = pend_q & ((state_q != ST_VALID) | pop_o);
      ram_re_o = ram_avail_i & (~pend_q | take);
      pend_d   = ram_re_o | (pend_q & ~take);
      if (take) data_d = ram_rdata_i;
      unique case (state_q)
        ST_EMPTY: if (ram_re_o) state_d = ST_LOAD;
        ST_LOAD:  state_d = ST_VALID;
        ST_VALID: begin
          if (pop_o) begin
            if (take)          state_d = ST_VALID;
            else if (ram_re_o) state_d = ST_LOAD;
            else               state_d = ST_EMPTY;
          end
        end
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      pend_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = (state_q == ST_VALID);

endmodule

// File: rtl/fifo_stream_fwft.sv
// Streaming FIFO with valid/ready on both sides, FWFT read data, live count,
// registered almost flags, synchronous flush and a sticky overflow flag.
module fifo_stream_fwft
  import fifo_stream_fwft_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int DEPTH              = 1024,
  parameter int ALMOST_FULL_THRES  = 8,
  parameter int ALMOST_EMPTY_THRES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - ALMOST_FULL_THRES);
  localparam logic [CW-1:0] AE_LVL   = CW'(ALMOST_EMPTY_THRES);

  logic                  push, pop, ram_re, ram_avail;
  logic [CW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ready_q, af_q, ae_q, ovf_q;

  assign push      = wr_valid & wr_ready_q & ~flush;
  assign ram_avail = (wr_ptr != rd_ptr);

  fifo_counter #(.WIDTH(CW)) u_wr_ptr (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(flush), .en_i(push), .cnt_o(wr_ptr)
  );

  fifo_counter #(.WIDTH(CW)) u_rd_ptr (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(flush), .en_i(ram_re), .cnt_o(rd_ptr)
  );

  block_ram_single_port #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(AW), .OUTPUT_REGISTER("false")
  ) u_ram (
    .clk_i(clk), .we_i(push), .waddr_i(wr_ptr[AW-1:0]), .wdata_i(wr_data),
    .re_i(ram_re), .raddr_i(rd_ptr[AW-1:0]), .rdata_o(ram_rdata)
  );

  fifo_fwft_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .ram_avail_i(ram_avail),
    .ram_rdata_i(ram_rdata), .ram_re_o(ram_re), .rd_ready_i(rd_ready),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .pop_o(pop)
  );

  always_comb begin
    count_d = count_q;
    if (flush)             count_d = '0;
    else if (push & ~pop)  count_d = count_q + 1'b1;
    else if (pop & ~push)  count_d = count_q - 1'b1;
  end

  // Flags are computed from count_d so they move on the same edge as count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wr_ready_q <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ready_q <= (count_d < FULL_LVL);
      af_q       <= (count_d >= AF_LVL);
      ae_q       <= (count_d <= AE_LVL);
      ovf_q      <= flush ? 1'b0 : (ovf_q | (wr_valid & ~wr_ready_q));
    end
  end

  assign count        = count_q;
  assign wr_ready     = wr_ready_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;

endmodule
